// File: rtl/iterative_alu.sv
// MIPS-style ALU: logic, arithmetic and HI/LO ops finish in one cycle; shift-add multiply and restoring divide take WIDTH cycles.
// Latency: 1 cycle, or WIDTH+1 for mul/div. InReady drops while iterating, and requests seen during that time are dropped, not queued.
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       Ctl,
  input  logic [WIDTH-1:0] ReadData0,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic             Exp,
  input  logic [31:0]      PCValue,
  output logic             OutValid,
  output logic [WIDTH-1:0] Res,
  output logic             Zero,
  output logic             Ovf,
  output logic             DivZero,
  output logic [31:0]      ExcPC,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_SLL  = 5'b01000, OP_SRL  = 5'b01001, OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_ADD  = 5'b00010, OP_SUB  = 5'b00110, OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001, OP_XOR  = 5'b00011, OP_NOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00111, OP_SLTU = 5'b00101;
  localparam logic [4:0] OP_MULT = 5'b10000, OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV  = 5'b10010, OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b10100, OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110, OP_MTLO = 5'b10111;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0] opb, dvd;
  logic neg_q, neg_r, dz;

  logic accept, is_mul, is_div, sgn_op;
  logic [WIDTH-1:0] a, b, a_mag, b_mag, sum, diff, alu_res;
  logic alu_ovf;

  assign InReady = (state == IDLE);
  assign accept  = InValid && InReady;
  assign a       = ReadData0;
  assign b       = ReadData1;
  assign is_mul  = (Ctl == OP_MULT) || (Ctl == OP_MULTU);
  assign is_div  = (Ctl == OP_DIV) || (Ctl == OP_DIVU);
  assign sgn_op  = (Ctl == OP_MULT) || (Ctl == OP_DIV);
  assign a_mag   = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (sgn_op && b[WIDTH-1]) ? -b : b;
  assign sum     = a + b;
  assign diff    = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (Ctl)
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: alu_res = Hi;
      OP_MFLO: alu_res = Lo;
      OP_MTHI: alu_res = a;
      OP_MTLO: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0] mul_sum, div_sh;
  logic [WIDTH-1:0] div_diff, q_raw, r_raw, hi_fin, lo_fin;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
  logic div_ge;

  assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? opb : {WIDTH{1'b0}})};
  assign mul_step = {mul_sum, p[WIDTH-1:1]};
  assign div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb};
  assign div_diff = div_sh[WIDTH-1:0] - opb;
  assign div_step = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
  assign prod     = neg_q ? -mul_step : mul_step;
  assign q_raw    = div_step[WIDTH-1:0];
  assign r_raw    = div_step[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_fin = prod[2*WIDTH-1:WIDTH];
    lo_fin = prod[WIDTH-1:0];
    if (state == DIV) begin
      if (dz) begin
        hi_fin = dvd;
        lo_fin = '1;
      end else begin
        hi_fin = neg_r ? -r_raw : r_raw;
        lo_fin = neg_q ? -q_raw : q_raw;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL, DIV: if (cnt == CNT_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid <= 1'b0;
      Res      <= '0;
      Zero     <= 1'b0;
      Ovf      <= 1'b0;
      DivZero  <= 1'b0;
      ExcPC    <= '0;
      Hi       <= '0;
      Lo       <= '0;
      cnt      <= '0;
      p        <= '0;
      opb      <= '0;
      dvd      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      Ovf      <= 1'b0;
      DivZero  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_mul || is_div) begin
              p     <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
              opb   <= is_mul ? a_mag : b_mag;
              dvd   <= a;
              neg_q <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= sgn_op && a[WIDTH-1];
              dz    <= (b == '0);
            end else begin
              OutValid <= 1'b1;
              Res      <= alu_res;
              Zero     <= (alu_res == '0);
              Ovf      <= Exp && alu_ovf;
              if (Exp && alu_ovf) ExcPC <= PCValue;
              if (Ctl == OP_MTHI) Hi <= a;
              if (Ctl == OP_MTLO) Lo <= a;
            end
          end
        end
        MUL, DIV: begin
          p   <= (state == MUL) ? mul_step : div_step;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            Hi       <= hi_fin;
            Lo       <= lo_fin;
            OutValid <= 1'b1;
            Res      <= lo_fin;
            Zero     <= (lo_fin == '0);
            DivZero  <= (state == DIV) && dz;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL take parameter WIDTH, default 32, datapath width in bits (legal values 8..64, power of two).
REQ-002 SHALL take parameter SHW, default $clog2(WIDTH), shift-amount width in bits.
REQ-003 SHALL have port Clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-005 SHALL have port InValid  input  1  operation request present.
REQ-006 SHALL have port InReady  output  1  block can accept a request this cycle.
REQ-007 SHALL have port Ctl  input  5  operation code (REQ-014).
REQ-008 SHALL have ports ReadData0, ReadData1  input  WIDTH  operands A and B.
REQ-009 SHALL have ports Exp  input  1 (overflow checking enabled) and PCValue  input  32 (instruction address).
REQ-010 SHALL have ports OutValid  output  1 (one-cycle result strobe), Res  output  WIDTH, Zero  output  1 (Res == 0).
REQ-011 SHALL have ports Ovf  output  1 (signed overflow with Exp), DivZero  output  1, ExcPC  output  32 (PCValue of the op that set Ovf).
REQ-012 SHALL have ports Hi, Lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-013 SHALL accept a request on an edge where InValid && InReady; InReady = 1 only in state IDLE.
REQ-014 Ctl codes SHALL be: 01000 SLL, 01001 SRL, 01011 SRA, 00010 ADD, 00110 SUB, 00000 AND, 00001 OR, 00011 XOR, 00100 NOR, 00111 SLT, 00101 SLTU, 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU, 10100 MFHI, 10101 MFLO, 10110 MTHI, 10111 MTLO; any other code SHALL yield Res = 0 with OutValid.
REQ-015 Shifts SHALL use only ReadData1[SHW-1:0] as amount; SRA sign-fills.
REQ-016 SLT/SLTU SHALL give Res = {WIDTH-1 zeros, flag}.
REQ-017 Single-cycle ops (all except MULT/MULTU/DIV/DIVU) SHALL register Res, Zero, flags on the accept edge; OutValid = 1 for exactly the following cycle; state stays IDLE.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH; Ovf SHALL be set for that result cycle iff Exp = 1 and signed overflow occurred, with ExcPC = PCValue; Res still updated; no simulation stop.
REQ-019 MTHI/MTLO SHALL write ReadData0 into Hi/Lo at the accept edge; Res = ReadData0.
REQ-020 MFHI/MFLO SHALL give Res = Hi/Lo as held before the accept edge.
REQ-021 FSM SHALL have states IDLE, MUL, DIV; MULT/MULTU accept -> MUL, DIV/DIVU accept -> DIV; MUL/DIV -> IDLE after exactly WIDTH busy cycles.
REQ-022 MUL SHALL be shift-add, one bit per cycle; signed form on operand magnitudes with final negation; {Hi,Lo} = full 2*WIDTH-bit product.
REQ-023 DIV SHALL be restoring, one quotient bit per cycle; Lo = quotient truncated toward zero, Hi = remainder with dividend's sign.
REQ-024 Iterative ops SHALL update Hi/Lo on the final busy edge, with OutValid = 1, Res = Lo, Zero = (Lo == 0) in the next cycle (OutValid WIDTH+1 cycles after accept).
REQ-025 Divisor 0 SHALL complete with same latency, Lo = all ones, Hi = dividend, DivZero = 1 with OutValid; Hi/Lo otherwise untouched.
REQ-026 Signed DIV of most-negative by -1 SHALL give Lo = most-negative, Hi = 0, no flag.
REQ-027 Ovf, DivZero SHALL be valid only while OutValid = 1 and 0 otherwise.
REQ-028 Requests while InReady = 0 SHALL be ignored, not queued; inputs need not be held after accept.

Reset
REQ-029 Reset = 1 SHALL force state IDLE, OutValid/Ovf/DivZero/Zero = 0, Res/Hi/Lo/ExcPC = 0, InReady = 1 from the next cycle.
REQ-030 Reset mid-MUL/DIV SHALL abandon the op without any OutValid or Hi/Lo update; Reset SHALL override a same-edge accept.

Verification
REQ-031 ADD 7FFFFFFF+1, Exp=1, PCValue=00400010 (WIDTH=32) -> next cycle OutValid, Res=80000000, Ovf=1, ExcPC=00400010; same with Exp=0 -> Ovf=0.
REQ-032 MULT FFFFFFFE x 00000003 -> InReady low 32 cycles, OutValid at cycle 33, Hi=FFFFFFFF, Lo=FFFFFFFA, Res=FFFFFFFA.
REQ-033 DIV FFFFFFF9 / 00000002 -> Lo=FFFFFFFD, Hi=FFFFFFFF; DIVU 7 / 0 -> Lo=FFFFFFFF, Hi=00000007, DivZero=1.
REQ-034 SRA F0000000 by 00000024 -> amount 4, Res=FF000000; SUB 5-5 -> Res=0, Zero=1.
REQ-035 Reset at cycle 10 of DIV, then MFLO -> no OutValid for DIV, Res=0; back-to-back ADDs with InValid held -> one result per cycle.
REQ-036 Repeat REQ-032/033 at WIDTH=8 and 64 against a golden model; latency WIDTH+1.
